// File: rtl/shot_arbiter.sv
// shot_arbiter: hands out four shared projectile slots to two tanks.
// Each tank is limited by a per-grant cooldown and a per-tank slot cap.
// When both tanks qualify in the same cycle, round-robin picks the winner.
module shot_arbiter #(
  parameter int COOLDOWN     = 30,
  parameter int MAX_PER_TANK = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire_req1,
  input  logic       fire_req2,
  input  logic [3:0] slot_release,
  input  logic       game_over,
  output logic       grant1,
  output logic       grant2,
  output logic [1:0] grant_slot,
  output logic [3:0] slot_busy,
  output logic [3:0] slot_owner,
  output logic       cooldown1_active,
  output logic       cooldown2_active
);

  localparam int              CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
  // The cap is clamped to the slot count so it fits the 3-bit occupancy count.
  localparam logic [2:0]      CAP     = (MAX_PER_TANK > 4) ? 3'd4 : 3'(MAX_PER_TANK);

  logic            req1_q, req1_d, req2_q, req2_d;
  logic            pend1_q, pend1_d, pend2_q, pend2_d;
  logic [CD_W-1:0] cd1_q, cd1_d, cd2_q, cd2_d;
  logic            rr_q, rr_d;  // 0: tank 1 has priority, 1: tank 2 has priority
  logic [3:0]      slot_busy_q, slot_busy_d;
  logic [3:0]      slot_owner_q, slot_owner_d;
  logic            grant1_q, grant1_d, grant2_q, grant2_d;
  logic [1:0]      grant_slot_q, grant_slot_d;

  logic [2:0]      own1, own2;
  logic [1:0]      free_slot;
  logic            any_free, rise1, rise2, elig1, elig2, win1, win2;

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Eligibility, arbitration, slot allocation and next-state for all flops
  always_comb begin
    own1      = count_ones(slot_busy_q & ~slot_owner_q);
    own2      = count_ones(slot_busy_q & slot_owner_q);
    any_free  = ~&slot_busy_q;
    free_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!slot_busy_q[i]) free_slot = 2'(i);
    end

    rise1 = fire_req1 & ~req1_q;
    rise2 = fire_req2 & ~req2_q;

    // Occupancy is taken from the registered busy bits, so a slot released
    // this cycle becomes grantable only in the following cycle.
    elig1 = pend1_q && (cd1_q == '0) && (own1 < CAP) && any_free && !game_over;
    elig2 = pend2_q && (cd2_q == '0) && (own2 < CAP) && any_free && !game_over;
    win1  = elig1 && (!elig2 || !rr_q);
    win2  = elig2 && !win1;

    req1_d       = fire_req1;
    req2_d       = fire_req2;
    grant1_d     = win1;
    grant2_d     = win2;
    grant_slot_d = (win1 || win2) ? free_slot : 2'd0;
    slot_busy_d  = slot_busy_q & ~slot_release;
    slot_owner_d = slot_owner_q;

    // A new edge while a request is already pending is dropped, not queued.
    pend1_d = win1 ? 1'b0 : (pend1_q | rise1);
    pend2_d = win2 ? 1'b0 : (pend2_q | rise2);

    cd1_d = win1 ? CD_LOAD : ((cd1_q != '0) ? cd1_q - CD_ONE : cd1_q);
    cd2_d = win2 ? CD_LOAD : ((cd2_q != '0) ? cd2_q - CD_ONE : cd2_q);

    if (win1)      rr_d = 1'b1;
    else if (win2) rr_d = 1'b0;
    else           rr_d = rr_q;

    if (win1 || win2) begin
      slot_busy_d[free_slot]  = 1'b1;
      slot_owner_d[free_slot] = win2;
    end

    // The edge registers keep tracking the keys, so a key held through
    // game_over does not produce a late edge afterwards.
    if (game_over) begin
      pend1_d      = 1'b0;
      pend2_d      = 1'b0;
      cd1_d        = '0;
      cd2_d        = '0;
      rr_d         = 1'b0;
      slot_busy_d  = 4'b0000;
      slot_owner_d = 4'b0000;
    end
  end

  // State update; reset overrides every other input
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      req1_q       <= 1'b0;
      req2_q       <= 1'b0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      cd1_q        <= '0;
      cd2_q        <= '0;
      rr_q         <= 1'b0;
      slot_busy_q  <= 4'b0000;
      slot_owner_q <= 4'b0000;
      grant1_q     <= 1'b0;
      grant2_q     <= 1'b0;
      grant_slot_q <= 2'd0;
    end else begin
      req1_q       <= req1_d;
      req2_q       <= req2_d;
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      cd1_q        <= cd1_d;
      cd2_q        <= cd2_d;
      rr_q         <= rr_d;
      slot_busy_q  <= slot_busy_d;
      slot_owner_q <= slot_owner_d;
      grant1_q     <= grant1_d;
      grant2_q     <= grant2_d;
      grant_slot_q <= grant_slot_d;
    end
  end

  assign grant1           = grant1_q;
  assign grant2           = grant2_q;
  assign grant_slot       = grant_slot_q;
  assign slot_busy        = slot_busy_q;
  assign slot_owner       = slot_owner_q;
  assign cooldown1_active = (cd1_q != '0);
  assign cooldown2_active = (cd2_q != '0);

endmodule
